// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and defaults for the two-client multiplier arbiter.
package mult_arb_pkg;

   localparam int unsigned DEF_WIDTH          = 5;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

   localparam logic OWNER0 = 1'b0;
   localparam logic OWNER1 = 1'b1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      RESP      = 3'd4
   } state_e;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Client and multiplier-side signals of the arbiter; slave is the arbiter, master the environment.
interface mult_share_arbiter_if
   import mult_arb_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);
   logic                 req0, req1;
   logic [WIDTH-1:0]     x0, y0, x1, y1;
   logic                 gnt0, gnt1;
   logic [2*WIDTH-1:0]   res0, res1;
   logic                 res_valid0, res_valid1;
   logic                 res_ack0, res_ack1;
   logic                 err0, err1;
   logic                 mul_start;
   logic [WIDTH-1:0]     mul_x, mul_y;
   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_result;

   modport slave (
      input  req0, req1, x0, y0, x1, y1, res_ack0, res_ack1, mul_done, mul_result,
      output gnt0, gnt1, res0, res1, res_valid0, res_valid1, err0, err1,
             mul_start, mul_x, mul_y
   );

   modport master (
      output req0, req1, x0, y0, x1, y1, res_ack0, res_ack1, mul_done, mul_result,
      input  gnt0, gnt1, res0, res1, res_valid0, res_valid1, err0, err1,
             mul_start, mul_x, mul_y
   );
endinterface

// File: rtl/mult_share_arbiter_timeout.sv
// Watchdog counter: synchronous clear, count enable, registered terminal-count flag.
module arb_timeout_counter
   import mult_arb_pkg::*;
#(
   parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int unsigned     CW   = (LIMIT > 2) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0]   TERM = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tc_q;

   // Saturates at TERM so the flag stays up until the next clear.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != TERM))
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= !clr_i && (cnt_d == TERM);
      end
   end

   assign tc_o = tc_q;
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer for one shared Booth multiplier serving two clients.
// Optional watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter
   import mult_arb_pkg::*;
#(
   parameter int unsigned WIDTH          = DEF_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input logic                  clk,
   input logic                  rst_n,
   mult_share_arbiter_if.slave  arb_if
);
   localparam int unsigned PW = 2 * WIDTH;

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             ptr_q, ptr_d;
   logic             tmo;
   logic             ack_own;
   logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d, start_q, start_d;
   logic             rv0_q, rv0_d, rv1_q, rv1_d, err0_q, err0_d, err1_q, err1_d;
   logic [PW-1:0]    res0_q, res0_d, res1_q, res1_d;
   logic [WIDTH-1:0] mx_q, mx_d, my_q, my_d;

`ifdef MULT_ARB_TIMEOUT_EN
   arb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (state_q == ISSUE),
      .en_i  ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)),
      .tc_o  (tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   assign ack_own = (owner_q == OWNER1) ? arb_if.res_ack1 : arb_if.res_ack0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= OWNER0;
         ptr_q   <= OWNER1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   // On a tie the requester not served last wins.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (arb_if.req0 || arb_if.req1) begin
               state_d = ISSUE;
               if (arb_if.req0 && arb_if.req1) owner_d = ~ptr_q;
               else                            owner_d = arb_if.req1 ? OWNER1 : OWNER0;
            end
         end
         ISSUE:     state_d = WAIT_BUSY;
         WAIT_BUSY: begin
            if (!arb_if.mul_done) state_d = WAIT_DONE;
            else if (tmo)         state_d = RESP;
         end
         WAIT_DONE: begin
            if (arb_if.mul_done || tmo) state_d = RESP;
         end
         RESP: begin
            if (ack_own) begin
               ptr_d   = owner_q;
               state_d = IDLE;
            end
         end
         default:   state_d = IDLE;
      endcase
   end

   // Output next-values; pulses and valids follow the next state, data holds unless captured.
   always_comb begin
      mx_d    = mx_q;
      my_d    = my_q;
      res0_d  = res0_q;
      res1_d  = res1_q;
      err0_d  = err0_q;
      err1_d  = err1_q;
      gnt0_d  = (state_d == ISSUE) && (owner_d == OWNER0);
      gnt1_d  = (state_d == ISSUE) && (owner_d == OWNER1);
      start_d = (state_d == ISSUE);
      rv0_d   = (state_d == RESP) && (owner_d == OWNER0);
      rv1_d   = (state_d == RESP) && (owner_d == OWNER1);
      if ((state_q == IDLE) && (state_d == ISSUE)) begin
         mx_d = (owner_d == OWNER1) ? arb_if.x1 : arb_if.x0;
         my_d = (owner_d == OWNER1) ? arb_if.y1 : arb_if.y0;
      end
      if (((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) && (state_d == RESP)) begin
         if ((state_q == WAIT_DONE) && arb_if.mul_done) begin
            if (owner_q == OWNER1) begin res1_d = arb_if.mul_result; err1_d = 1'b0; end
            else                   begin res0_d = arb_if.mul_result; err0_d = 1'b0; end
         end else begin
            if (owner_q == OWNER1) begin res1_d = '0; err1_d = 1'b1; end
            else                   begin res0_d = '0; err0_d = 1'b1; end
         end
      end
      if ((state_q == RESP) && (state_d == IDLE)) begin
         if (owner_q == OWNER1) err1_d = 1'b0;
         else                   err0_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0_q <= 1'b0; gnt1_q <= 1'b0; start_q <= 1'b0;
         rv0_q  <= 1'b0; rv1_q  <= 1'b0; err0_q  <= 1'b0; err1_q <= 1'b0;
         res0_q <= '0;   res1_q <= '0;   mx_q    <= '0;   my_q   <= '0;
      end else begin
         gnt0_q <= gnt0_d; gnt1_q <= gnt1_d; start_q <= start_d;
         rv0_q  <= rv0_d;  rv1_q  <= rv1_d;  err0_q  <= err0_d;  err1_q <= err1_d;
         res0_q <= res0_d; res1_q <= res1_d; mx_q    <= mx_d;    my_q   <= my_d;
      end
   end

   assign arb_if.gnt0       = gnt0_q;
   assign arb_if.gnt1       = gnt1_q;
   assign arb_if.mul_start  = start_q;
   assign arb_if.mul_x      = mx_q;
   assign arb_if.mul_y      = my_q;
   assign arb_if.res0       = res0_q;
   assign arb_if.res1       = res1_q;
   assign arb_if.res_valid0 = rv0_q;
   assign arb_if.res_valid1 = rv1_q;
   assign arb_if.err0       = err0_q;
   assign arb_if.err1       = err1_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural busy-length-programmable multiplier.
module tb_mult_share_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mult_share_arbiter_if #(.WIDTH(5)) bus ();

   mult_share_arbiter #(.WIDTH(5), .TIMEOUT_CYCLES(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_if (bus)
   );

   // Multiplier model: Done drops for b_len cycles after a sampled Start.
   int unsigned       b_len;
   logic              stuck;
   logic [7:0]        busy;
   logic [9:0]        prod;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
         prod <= '0;
      end else if (bus.mul_start && (busy == 8'd0)) begin
         busy <= 8'(b_len);
         prod <= 10'(signed'(bus.mul_x)) * 10'(signed'(bus.mul_y));
      end else if (busy != 8'd0) begin
         busy <= busy - 8'd1;
      end
   end
   assign bus.mul_done   = !stuck && (busy == 8'd0);
   assign bus.mul_result = prod;

   int n_vec = 0;
   int n_err = 0;
   int g0, g1, st, rv0_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs until either res_valid rises; drops each req once its gnt is seen.
   task automatic wait_valid(output int who, output int cyc);
      who = -1; cyc = 0; g0 = 0; g1 = 0; st = 0; rv0_seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         if (bus.gnt0) begin g0++; bus.req0 = 1'b0; end
         if (bus.gnt1) begin g1++; bus.req1 = 1'b0; end
         if (bus.mul_start) st++;
         if (bus.res_valid0) begin who = 0; break; end
         if (bus.res_valid1) begin who = 1; break; end
      end
   endtask

   task automatic do_ack(input int who);
      if (who == 0) bus.res_ack0 = 1'b1; else bus.res_ack1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.res_ack0 = 1'b0;
      bus.res_ack1 = 1'b0;
      check("ack_clears_valid", 32'({bus.res_valid1, bus.res_valid0}), 32'd0);
   endtask

   int who, cyc, c;

   initial begin
      rst_n = 1'b0; stuck = 1'b0; b_len = 20;
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.res_ack0 = 1'b0; bus.res_ack1 = 1'b0;
      bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
      repeat (2) @(negedge clk);
      check("rst_pulses",  32'({bus.gnt0, bus.gnt1, bus.mul_start}), 32'd0);
      check("rst_valid",   32'({bus.res_valid0, bus.res_valid1, bus.err0, bus.err1}), 32'd0);
      check("rst_res",     32'({bus.res0, bus.res1}), 32'd0);
      check("rst_mulxy",   32'({bus.mul_x, bus.mul_y}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single request, B=20: 7*3 = 21 after 23 cycles.
      bus.x0 = 5'd7; bus.y0 = 5'd3; bus.req0 = 1'b1;
      wait_valid(who, cyc);
      check("single_owner",   32'(who), 32'd0);
      check("single_latency", 32'(cyc), 32'd23);
      check("single_gnt0",    32'(g0), 32'd1);
      check("single_gnt1",    32'(g1), 32'd0);
      check("single_start",   32'(st), 32'd1);
      check("single_res0",    32'(bus.res0), 32'd21);
      check("single_err0",    32'(bus.err0), 32'd0);
      repeat (3) @(negedge clk);
      check("single_hold",    32'({bus.res_valid0, bus.res0}), 32'({1'b1, 10'd21}));
      do_ack(0);

      // Negative operand on requester 1: -4*6 = -24.
      b_len = 3;
      bus.x1 = 5'b11100; bus.y1 = 5'd6; bus.req1 = 1'b1;
      wait_valid(who, cyc);
      check("neg_owner",   32'(who), 32'd1);
      check("neg_latency", 32'(cyc), 32'd6);
      check("neg_res1",    32'(bus.res1), 32'h3E8);
      check("neg_rv0",     32'(bus.res_valid0), 32'd0);
      do_ack(1);

      // Tie right after reset: requester 0 first, then 1.
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
      b_len = 2;
      bus.x0 = 5'd2; bus.y0 = 5'd5; bus.x1 = 5'b11101; bus.y1 = 5'b11101;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      wait_valid(who, cyc);
      check("tie1_first",  32'(who), 32'd0);
      check("tie1_res0",   32'(bus.res0), 32'd10);
      check("tie1_nognt1", 32'(g1), 32'd0);
      do_ack(0);
      wait_valid(who, cyc);
      check("tie1_second", 32'(who), 32'd1);
      check("tie1_res1",   32'(bus.res1), 32'd9);
      do_ack(1);

      // Second tie: pointer is 1, so requester 0 wins; then delayed ack.
      bus.x0 = 5'b10000; bus.y0 = 5'b10000; bus.x1 = 5'd15; bus.y1 = 5'b11111;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      wait_valid(who, cyc);
      check("tie2_first", 32'(who), 32'd0);
      check("tie2_res0",  32'(bus.res0), 32'h100);
      c = 0; g1 = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); @(negedge clk);
         if (bus.res_valid0 && (bus.res0 == 10'h100)) c++;
         if (bus.gnt1) g1++;
      end
      check("dack_stable", 32'(c), 32'd10);
      check("dack_nognt1", 32'(g1), 32'd0);
      bus.res_ack0 = 1'b1;
      c = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); c++;
         @(negedge clk);
         bus.res_ack0 = 1'b0;
         if (bus.gnt1) break;
      end
      check("dack_gnt1_delay", 32'(c), 32'd2);
      bus.req1 = 1'b0;
      wait_valid(who, cyc);
      check("dack_owner1", 32'(who), 32'd1);
      check("dack_res1",   32'(bus.res1), 32'h3F1);
      do_ack(1);

`ifdef MULT_ARB_TIMEOUT_EN
      // Done stuck low: watchdog forces an error response.
      stuck = 1'b1;
      bus.x0 = 5'd3; bus.y0 = 5'd3; bus.req0 = 1'b1;
      wait_valid(who, cyc);
      check("tmo_owner",   32'(who), 32'd0);
      check("tmo_latency", 32'(cyc), 32'd10);
      check("tmo_err0",    32'(bus.err0), 32'd1);
      check("tmo_res0",    32'(bus.res0), 32'd0);
      do_ack(0);
      check("tmo_err_clr", 32'(bus.err0), 32'd0);
`endif

      // Reset while waiting on Done clears every output without a clock edge.
      stuck = 1'b1;
      bus.x1 = 5'd9; bus.y1 = 5'd2; bus.req1 = 1'b1;
      c = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (bus.gnt1) begin bus.req1 = 1'b0; c = 1; break; end
      end
      check("mid_granted", 32'(c), 32'd1);
      repeat (4) @(negedge clk);
      check("mid_mulx",  32'(bus.mul_x), 32'd9);
      check("mid_norv",  32'(bus.res_valid1), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_pulses", 32'({bus.gnt0, bus.gnt1, bus.mul_start}), 32'd0);
      check("arst_valid",  32'({bus.res_valid0, bus.res_valid1, bus.err0, bus.err1}), 32'd0);
      check("arst_res",    32'({bus.res0, bus.res1}), 32'd0);
      check("arst_mulxy",  32'({bus.mul_x, bus.mul_y}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; stuck = 1'b0;
      @(negedge clk);

      // Recovery with the shortest busy period: 1*-1 = -1, latency 3+B.
      b_len = 1;
      bus.x0 = 5'd1; bus.y0 = 5'b11111; bus.req0 = 1'b1;
      wait_valid(who, cyc);
      check("rec_owner",   32'(who), 32'd0);
      check("rec_latency", 32'(cyc), 32'd4);
      check("rec_res0",    32'(bus.res0), 32'h3FF);
      do_ack(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1);
   end
endmodule
